uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver for the MiniCalc2 board top. It takes the raw `IO_RXD` pin, resynchronises it and recovers 8N1 frames. Each frame is presented as a byte with a one-cycle valid strobe for the calculator core, which consumes received operands and commands. It also reports framing errors and line-busy status to the core and LEDs.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range 4..65535.
- `DATA_BITS`, default 8: payload bits per frame, LSB first.

Ports:
- `Clk`, input, 1: system clock. All logic is on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `Rx`, input, 1: raw asynchronous serial line. Idle level is high.
- `Data`, output, `DATA_BITS`: last correctly framed byte. Held until the next good frame.
- `DataValid`, output, 1: one-cycle pulse when `Data` is updated.
- `FramingError`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `Busy`, output, 1: high from start-bit detection until return to IDLE.

## Operation
- `Rx` passes through a 2-flop synchroniser to give `RxS`. All decisions use `RxS` only.
- States: IDLE, START, DATA, STOP, WAIT_HIGH. The bit counter `Cnt` runs 0..`CLKS_PER_BIT`-1. The bit index `Idx` runs 0..`DATA_BITS`-1.
- **IDLE**: `Cnt`=0. If `RxS`=0, go to START.
- **START**: count up until `Cnt`=`CLKS_PER_BIT`/2-1 (integer division). That cycle samples `RxS`:
  - `RxS`=0: go to DATA with `Cnt`=0 and `Idx`=0.
  - `RxS`=1: treat as a glitch and return to IDLE. No error is flagged.
- **DATA**: when `Cnt`=`CLKS_PER_BIT`-1, shift `RxS` into the shift register MSB; the register shifts right, so the first received bit ends up as `Data[0]`. Then clear `Cnt` and increment `Idx`. After bit `DATA_BITS`-1, go to STOP.
- **STOP**: when `Cnt`=`CLKS_PER_BIT`-1, sample `RxS`:
  - 1: load `Data` from the shift register, pulse `DataValid`, go to IDLE.
  - 0: pulse `FramingError`, leave `Data` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH**: stay until `RxS`=1, then go to IDLE. This covers break conditions: a line held low produces exactly one `FramingError` and no spurious re-triggers.
- `Busy`=1 in START, DATA, STOP and WAIT_HIGH.
- `DataValid` and `FramingError` are never high in the same cycle.

## Timing
- Reset values: state IDLE, `Data`=0, `DataValid`=0, `FramingError`=0, `Busy`=0, `Cnt`=0, `Idx`=0, synchroniser flops=1.
- Reset mid-frame abandons the frame. No pulse is emitted. Reception resumes on the next falling edge after `Reset` deasserts.
- Input latency: an edge on `Rx` reaches `RxS` 2 cycles later.
- Let H=`CLKS_PER_BIT`/2 and N=`CLKS_PER_BIT`. Measured from the first cycle `RxS`=0 is seen in IDLE:
  - START samples at cycle H.
  - Data bit k is sampled at cycle H+(k+1)·N.
  - The stop bit is sampled at H+(`DATA_BITS`+1)·N.
  - `DataValid` or `FramingError` is registered high in the following cycle.
- Back-to-back frames: IDLE is re-entered about N/2 before the nominal stop-bit end, so a start edge immediately after the stop bit is detected.
- `Data` changes only in the same cycle `DataValid` rises.
- No backpressure. The consumer must accept `Data` on the `DataValid` pulse.

## Structure
- Shared include `uart_defs.vh` holds:
  - state encodings (`UART_RX_IDLE` … `UART_RX_WAIT_HIGH`, 3 bits);
  - the default baud constant `UART_CLKS_PER_BIT_115200` = 434.
- A future `uart_transmitter` reuses the same header.
- Sub-module: the existing `Synchronizer` component, instantiated once on `Rx`.
- FSM, counters and shift register are inline in this module.

## Test plan
All scenarios use `CLKS_PER_BIT`=8, `DATA_BITS`=8.
- Reset, then idle line held high for 200 cycles -> `Busy`, `DataValid` and `FramingError` stay 0; `Data`=0x00.
- Send 0xA5 at 8 cycles/bit with a good stop bit -> exactly one `DataValid`, `Data`=0xA5, pulse 2+4+9·8+1 cycles after the `Rx` falling edge (±1). `Busy` falls the cycle after.
- Send 0x3C and 0xFF back-to-back with no idle gap -> two `DataValid` pulses with `Data`=0x3C then 0xFF; no `FramingError`.
- Drive a 2-cycle low glitch on idle `Rx` -> returns to IDLE after the START sample; no pulses; `Busy` high for about 4 cycles only.
- Send 0x55 with stop bit low, then hold `Rx` low for 100 cycles -> one `FramingError`, `Data` keeps its previous value, `Busy` stays high until `Rx` returns high, no further pulses.
- Assert `Reset` during bit 4 of a frame -> all outputs go to 0 next cycle. A subsequent clean 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver state encodings and the default baud constant.
// The transmitter is meant to reuse this package as well.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    UART_RX_IDLE      = 3'd0,
    UART_RX_START     = 3'd1,
    UART_RX_DATA      = 3'd2,
    UART_RX_STOP      = 3'd3,
    UART_RX_WAIT_HIGH = 3'd4
  } rx_state_e;

  // 50 MHz system clock at 115200 baud
  localparam int unsigned UART_CLKS_PER_BIT_115200 = 434;

  // Wide enough for the largest legal CLKS_PER_BIT (65535)
  localparam int unsigned UART_CNT_W = 16;

endpackage

// File: rtl/uart_receiver_sync.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RESET_VAL so an idle-high line does not look like an edge.
module uart_receiver_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: resynchronises Rx, recovers frames, and reports
// each good byte with a one-cycle DataValid strobe or a bad stop bit with FramingError.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Data,
  output logic                 DataValid,
  output logic                 FramingError,
  output logic                 Busy
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [UART_CNT_W-1:0] HALF_M1  = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [UART_CNT_W-1:0] FULL_M1  = UART_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rxs;

  rx_state_e                state_q, state_d;
  logic [UART_CNT_W-1:0]    cnt_q,   cnt_d;
  logic [IDX_W-1:0]         idx_q,   idx_d;
  logic [DATA_BITS-1:0]     sh_q,    sh_d;
  logic [DATA_BITS-1:0]     data_q,  data_d;
  logic                     dv_q,    dv_d;
  logic                     fe_q,    fe_d;

  uart_receiver_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i(Clk),
    .rst_i(Reset),
    .d_i  (Rx),
    .q_o  (rxs)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= UART_RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;

    case (state_q)
      UART_RX_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = UART_RX_START;
      end

      // Mid-start-bit check rejects short glitches without flagging an error
      UART_RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? UART_RX_IDLE : UART_RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      UART_RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          sh_d               = sh_q >> 1;
          sh_d[DATA_BITS-1]  = rxs;
          idx_d              = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = UART_RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving at mid-stop-bit gives half a bit of slack for the next start edge
      UART_RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = sh_q;
            dv_d    = 1'b1;
            state_d = UART_RX_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = UART_RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      UART_RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) state_d = UART_RX_IDLE;
      end

      default: state_d = UART_RX_IDLE;
    endcase
  end

  assign Data         = data_q;
  assign DataValid    = dv_q;
  assign FramingError = fe_q;
  assign Busy         = (state_q != UART_RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scenario bench for uart_receiver at 8 clocks per bit: expected bytes go into a
// scoreboard queue as frames are driven and are checked as DataValid pulses appear.
module tb_uart_receiver;

  localparam int N  = 8;
  localparam int DB = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Rx = 1'b1;
  logic [DB-1:0] Data;
  logic          DataValid;
  logic          FramingError;
  logic          Busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DB-1:0] sb[$];
  int            dv_cnt = 0;
  int            fe_cnt = 0;
  int            last_dv_cyc = 0;
  logic          dv_prev = 1'b0;
  logic          busy_after_dv = 1'b1;
  logic [DB-1:0] last_good = '0;

  uart_receiver #(
    .CLKS_PER_BIT(N),
    .DATA_BITS   (DB)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Rx          (Rx),
    .Data        (Data),
    .DataValid   (DataValid),
    .FramingError(FramingError),
    .Busy        (Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every DataValid pulse
  always @(negedge Clk) begin
    if (!Reset) begin
      if (dv_prev) busy_after_dv = Busy;
      if (DataValid) begin
        dv_cnt++;
        last_dv_cyc = cyc;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: DataValid with Data=%02h, no frame expected", Data);
        end else begin
          logic [DB-1:0] exp;
          exp = sb.pop_front();
          if (Data !== exp) begin
            fails++;
            $display("FAIL sb_data: got %02h, expected %02h", Data, exp);
          end
        end
      end
      if (FramingError) fe_cnt++;
      if (DataValid && FramingError) begin
        tests++;
        fails++;
        $display("FAIL dv_fe_overlap: DataValid=%b FramingError=%b, expected not both", DataValid, FramingError);
      end
      dv_prev = DataValid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (N) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic wait_dv(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (dv_cnt < target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (dv_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: DataValid count %0d, expected %0d", name, dv_cnt, target);
    end
  endtask

  task automatic test_reset();
    logic seen;
    Reset = 1'b1;
    Rx = 1'b1;
    repeat (3) @(negedge Clk);
    tests++;
    if ({DataValid, FramingError, Busy} !== 3'b000 || Data !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: dv=%b fe=%b busy=%b data=%02h, expected 0 0 0 00",
               DataValid, FramingError, Busy, Data);
    end
    Reset = 1'b0;
    seen = 1'b0;
    repeat (200) begin
      @(negedge Clk);
      if (Busy || DataValid || FramingError) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0 || Data !== 8'h00) begin
      fails++;
      $display("FAIL idle_quiet: activity=%b data=%02h, expected 0 and 00", seen, Data);
    end
  endtask

  task automatic test_single();
    int fall, dv0, lat;
    dv0 = dv_cnt;
    sb.push_back(8'hA5);
    last_good = 8'hA5;
    fall = cyc;
    drive_bit(1'b0);
    tests++;
    if (Busy !== 1'b1) begin
      fails++;
      $display("FAIL single_busy_mid: got %b, expected 1", Busy);
    end
    for (int i = 0; i < DB; i++) drive_bit(last_good[i]);
    drive_bit(1'b1);
    wait_dv(dv0 + 1, 20, "single");
    repeat (10) @(negedge Clk);
    lat = last_dv_cyc - fall;
    tests++;
    if (dv_cnt - dv0 !== 1) begin
      fails++;
      $display("FAIL single_count: %0d pulses, expected 1", dv_cnt - dv0);
    end
    tests++;
    if (lat < 78 || lat > 80) begin
      fails++;
      $display("FAIL single_latency: %0d cycles, expected 79 +/-1", lat);
    end
    tests++;
    if (busy_after_dv !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_fall: Busy=%b the cycle after DataValid, expected 0", busy_after_dv);
    end
  endtask

  task automatic test_back_to_back();
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    sb.push_back(8'h3C);
    sb.push_back(8'hFF);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    last_good = 8'hFF;
    wait_dv(dv0 + 2, 20, "b2b");
    repeat (10) @(negedge Clk);
    tests++;
    if (dv_cnt - dv0 !== 2 || fe_cnt - fe0 !== 0 || sb.size() !== 0) begin
      fails++;
      $display("FAIL b2b_counts: dv=%0d fe=%0d pending=%0d, expected 2 0 0",
               dv_cnt - dv0, fe_cnt - fe0, sb.size());
    end
  endtask

  task automatic test_glitch();
    int dv0, fe0, busy_cycles;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    busy_cycles = 0;
    Rx = 1'b0;
    repeat (2) @(negedge Clk);
    Rx = 1'b1;
    repeat (30) begin
      @(negedge Clk);
      if (Busy) busy_cycles++;
    end
    tests++;
    if (busy_cycles < 3 || busy_cycles > 5) begin
      fails++;
      $display("FAIL glitch_busy: busy for %0d cycles, expected about 4", busy_cycles);
    end
    tests++;
    if (dv_cnt != dv0 || fe_cnt != fe0) begin
      fails++;
      $display("FAIL glitch_pulses: dv=%0d fe=%0d, expected 0 0", dv_cnt - dv0, fe_cnt - fe0);
    end
  endtask

  task automatic test_framing();
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    Rx = 1'b0;
    repeat (100) @(negedge Clk);
    tests++;
    if (fe_cnt - fe0 !== 1 || Busy !== 1'b1) begin
      fails++;
      $display("FAIL frm_error: fe=%0d busy=%b during break, expected 1 1", fe_cnt - fe0, Busy);
    end
    tests++;
    if (Data !== last_good) begin
      fails++;
      $display("FAIL frm_data_hold: got %02h, expected %02h", Data, last_good);
    end
    Rx = 1'b1;
    repeat (10) @(negedge Clk);
    tests++;
    if (Busy !== 1'b0 || dv_cnt != dv0 || fe_cnt - fe0 !== 1) begin
      fails++;
      $display("FAIL frm_recover: busy=%b dv=%0d fe=%0d, expected 0 0 1",
               Busy, dv_cnt - dv0, fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_mid();
    logic [DB-1:0] b;
    int dv0;
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    Rx = b[4];
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    tests++;
    if ({DataValid, FramingError, Busy} !== 3'b000 || Data !== 8'h00) begin
      fails++;
      $display("FAIL rstmid_outputs: dv=%b fe=%b busy=%b data=%02h, expected 0 0 0 00",
               DataValid, FramingError, Busy, Data);
    end
    Rx = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
    dv0 = dv_cnt;
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    last_good = 8'h81;
    wait_dv(dv0 + 1, 20, "rstmid");
    repeat (5) @(negedge Clk);
    tests++;
    if (dv_cnt - dv0 !== 1 || Data !== 8'h81 || sb.size() !== 0) begin
      fails++;
      $display("FAIL rstmid_recover: dv=%0d data=%02h pending=%0d, expected 1 81 0",
               dv_cnt - dv0, Data, sb.size());
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
